// File: rtl/alk_pkg.sv
// Shared definitions for the ALK multiply/divide loop sequencer: ALPCTL micro-op
// codes, operation encoding and sequencer state encoding.
package alk_pkg;

  typedef enum logic [1:0] {
    ALK_OP_MUL  = 2'd0,
    ALK_OP_DIV  = 2'd1,
    ALK_OP_DIVD = 2'd2,
    ALK_OP_REM  = 2'd3
  } alk_mdop_t;

  typedef logic [2:0] alk_mdseq_state_t;

  localparam alk_mdseq_state_t ST_IDLE  = 3'd0;
  localparam alk_mdseq_state_t ST_FIRST = 3'd1;
  localparam alk_mdseq_state_t ST_LOOP  = 3'd2;
  localparam alk_mdseq_state_t ST_LAST  = 3'd3;
  localparam alk_mdseq_state_t ST_FIX   = 3'd4;
  localparam alk_mdseq_state_t ST_DONE  = 3'd5;

  // The P and N variants of each code differ only in bit 4.
  localparam logic [9:0] UC_ALPCTL_MULFASTP = 10'h269;
  localparam logic [9:0] UC_ALPCTL_MULFASTN = 10'h279;
  localparam logic [9:0] UC_ALPCTL_MULSLOWP = 10'h26B;
  localparam logic [9:0] UC_ALPCTL_MULSLOWN = 10'h27B;
  localparam logic [9:0] UC_ALPCTL_DIVFASTP = 10'h26C;
  localparam logic [9:0] UC_ALPCTL_DIVFASTN = 10'h27C;
  localparam logic [9:0] UC_ALPCTL_DIVSLOWP = 10'h26E;
  localparam logic [9:0] UC_ALPCTL_DIVSLOWN = 10'h27E;
  localparam logic [9:0] UC_ALPCTL_DIVDA    = 10'h26F;
  localparam logic [9:0] UC_ALPCTL_DIVDS    = 10'h27F;
  localparam logic [9:0] UC_ALPCTL_REM      = 10'h26A;

endpackage

// File: rtl/alk_mdcode.sv
// Combinational ALPCTL code and loop-flag selection for a given sequencer
// state, operation and registered sign.
module alk_mdcode
  import alk_pkg::*;
#(
  parameter logic [9:0] NOP_CODE = 10'h000
) (
  input  alk_mdseq_state_t state_i,
  input  alk_mdop_t        op_i,
  input  logic             neg_i,
  output logic [9:0]       alpctl_o,
  output logic             loop_flag_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    alpctl_o    = NOP_CODE;
    loop_flag_o = 1'b0;
    case (state_i)
      ST_FIRST, ST_LAST: begin
        case (op_i)
          ALK_OP_MUL:  alpctl_o = neg_i ? UC_ALPCTL_MULSLOWN : UC_ALPCTL_MULSLOWP;
          ALK_OP_DIVD: alpctl_o = neg_i ? UC_ALPCTL_DIVDS : UC_ALPCTL_DIVDA;
          default:     alpctl_o = neg_i ? UC_ALPCTL_DIVSLOWN : UC_ALPCTL_DIVSLOWP;
        endcase
      end
      ST_LOOP: begin
        case (op_i)
          ALK_OP_MUL: begin
            alpctl_o    = neg_i ? UC_ALPCTL_MULFASTN : UC_ALPCTL_MULFASTP;
            loop_flag_o = 1'b1;
          end
          // DIVD has no fast form; it keeps issuing the slow add/subtract step.
          ALK_OP_DIVD: alpctl_o = neg_i ? UC_ALPCTL_DIVDS : UC_ALPCTL_DIVDA;
          default: begin
            alpctl_o    = neg_i ? UC_ALPCTL_DIVFASTN : UC_ALPCTL_DIVFASTP;
            loop_flag_o = 1'b1;
          end
        endcase
      end
      ST_FIX:  alpctl_o = UC_ALPCTL_REM;
      default: alpctl_o = NOP_CODE;
    endcase
  end

endmodule

// File: rtl/alk_mdseq.sv
// Multiply/divide loop sequencer: issues one ALPCTL code per cycle for MUL, DIV,
// DIVD and REM, choosing P/N variants from datapath sign feedback.
module alk_mdseq
  import alk_pkg::*;
#(
  parameter int         CNT_W    = 6,
  parameter logic [9:0] NOP_CODE = 10'h000
) (
  input  logic             clk_h,
  input  logic             reset_h,
  input  logic             start_h,
  input  logic [1:0]       op_h,
  input  logic [CNT_W-1:0] cnt_h,
  input  logic             sel_neg_h,
  input  logic             hold_h,
  input  logic             kill_h,
  output logic [9:0]       alpctl_h,
  output logic             loop_flag_h,
  output logic             busy_h,
  output logic             done_h
);

  alk_mdseq_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  alk_mdop_t        op_q, op_d;
  logic             neg_q, neg_d;
  logic [9:0]       alpctl_q, alpctl_d, code_alpctl;
  logic             loop_flag_q, loop_flag_d, code_loop;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Saturating decrement: an exhausted count stays at zero.
  assign cnt_dec = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start_h) begin
          op_d  = alk_mdop_t'(op_h);
          cnt_d = cnt_h;
          neg_d = sel_neg_h;
          if (cnt_h == '0)               state_d = ST_DONE;
          else if (cnt_h == CNT_W'(1))   state_d = ST_LAST;
          else                           state_d = ST_FIRST;
        end
      end
      ST_FIRST: begin
        cnt_d   = cnt_dec;
        neg_d   = sel_neg_h;
        state_d = (cnt_q > CNT_W'(2)) ? ST_LOOP : ST_LAST;
      end
      ST_LOOP: begin
        cnt_d   = cnt_dec;
        neg_d   = sel_neg_h;
        state_d = (cnt_dec == CNT_W'(1)) ? ST_LAST : ST_LOOP;
      end
      ST_LAST: begin
        cnt_d = cnt_dec;
        neg_d = sel_neg_h;
        if (op_q == ALK_OP_REM || (op_q == ALK_OP_DIV && sel_neg_h)) state_d = ST_FIX;
        else                                                          state_d = ST_DONE;
      end
      ST_FIX: begin
        neg_d   = sel_neg_h;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (hold_h) begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_d   = neg_q;
    end
    if (kill_h) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // Codes are looked up for the state being entered so they appear registered
  // in the same cycle the FSM occupies that state.
  alk_mdcode #(.NOP_CODE(NOP_CODE)) u_code (
    .state_i     (state_d),
    .op_i        (op_d),
    .neg_i       (neg_d),
    .alpctl_o    (code_alpctl),
    .loop_flag_o (code_loop)
  );

  always_comb begin
    alpctl_d    = code_alpctl;
    loop_flag_d = code_loop;
    busy_d      = (state_d inside {ST_FIRST, ST_LOOP, ST_LAST, ST_FIX});
    done_d      = (state_d == ST_DONE);
    if (hold_h && !kill_h) begin
      alpctl_d    = alpctl_q;
      loop_flag_d = loop_flag_q;
      busy_d      = busy_q;
      done_d      = done_q;
    end
  end

  always_ff @(posedge clk_h) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset_h) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= ALK_OP_MUL;
      neg_q       <= 1'b0;
      alpctl_q    <= NOP_CODE;
      loop_flag_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      alpctl_q    <= alpctl_d;
      loop_flag_q <= loop_flag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign alpctl_h    = alpctl_q;
  assign loop_flag_h = loop_flag_q;
  assign busy_h      = busy_q;
  assign done_h      = done_q;

endmodule
